// File: rtl/dct16_odd_pkg.sv
// Shared constants for the 16-point DCT-II odd-part accumulator.
// Product-index and sign tables are derived from the odd coefficient matrix.
package dct16_odd_pkg;

    localparam int PW = 20;
    localparam int OW = 20;

    // Product index: 0..7 selects x9, x25, x43, x57, x70, x80, x87, x90.
    // Outer index is the row (y1, y3, ... y15); inner index is column n.
    localparam logic [2:0] PIDX [8][8] = '{
        '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
        '{3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1},
        '{3'd5, 3'd0, 3'd4, 3'd6, 3'd1, 3'd3, 3'd7, 3'd2},
        '{3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3},
        '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4},
        '{3'd2, 3'd7, 3'd3, 3'd1, 3'd6, 3'd4, 3'd0, 3'd5},
        '{3'd1, 3'd4, 3'd7, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6},
        '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}
    };

    // Negate mask per row: bit n set means column n is subtracted.
    localparam logic [7:0] NEG [8] = '{
        8'b0000_0000,
        8'b1111_1000,
        8'b0001_1100,
        8'b1100_0110,
        8'b0011_0110,
        8'b1001_0010,
        8'b0100_1010,
        8'b1010_1010
    };

endpackage

// File: rtl/dct16_odd_row.sv
// Per-row term selector: picks one magnitude product for the current
// column, sign-extends it and applies the matrix sign.
module dct16_odd_row
    import dct16_odd_pkg::*;
#(
    parameter int ROW = 0,
    parameter int PW_P = PW,
    parameter int OW_P = OW
) (
    input  logic [7:0][PW_P-1:0]   prods,
    input  logic [2:0]             col,
    output logic signed [OW_P-1:0] term
);

    logic [2:0]             sel;
    logic signed [OW_P-1:0] ext;

    // Select, sign-extend and conditionally negate the product.
    always_comb begin
        sel  = PIDX[ROW][col];
        ext  = OW_P'($signed(prods[sel]));
        term = NEG[ROW][col] ? -ext : ext;
    end

endmodule

// File: rtl/dct16_odd_acc.sv
// Serial accumulator forming the 8 odd DCT-II outputs from 8 product beats,
// with a single-entry output slot and valid/ready on both sides.
module dct16_odd_acc
    import dct16_odd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [PW-1:0] p9,
    input  logic signed [PW-1:0] p25,
    input  logic signed [PW-1:0] p43,
    input  logic signed [PW-1:0] p57,
    input  logic signed [PW-1:0] p70,
    input  logic signed [PW-1:0] p80,
    input  logic signed [PW-1:0] p87,
    input  logic signed [PW-1:0] p90,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] y1,
    output logic signed [OW-1:0] y3,
    output logic signed [OW-1:0] y5,
    output logic signed [OW-1:0] y7,
    output logic signed [OW-1:0] y9,
    output logic signed [OW-1:0] y11,
    output logic signed [OW-1:0] y13,
    output logic signed [OW-1:0] y15
);

    logic [7:0][PW-1:0]   prods;
    logic [2:0]           col;
    logic                 accept;
    logic                 last;
    logic signed [OW-1:0] term [8];
    logic signed [OW-1:0] sum  [8];
    logic signed [OW-1:0] acc  [8];
    logic signed [OW-1:0] yr   [8];

    assign prods = {p90, p87, p80, p70, p57, p43, p25, p9};

    // Only the completing beat stalls while a finished vector is unread.
    assign in_ready = !(col == 3'd7 && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = col == 3'd7;

    for (genvar r = 0; r < 8; r++) begin : g_row
        dct16_odd_row #(
            .ROW (r)
        ) u_row (
            .prods (prods),
            .col   (col),
            .term  (term[r])
        );
    end

    // Column 0 starts a fresh sum, so no separate clear cycle is needed.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            sum[r] = (col == 3'd0) ? term[r] : acc[r] + term[r];
        end
    end

    // Column counter, accumulators, output slot and its valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            out_valid <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                acc[r] <= '0;
                yr[r]  <= '0;
            end
        end else begin
            if (accept) begin
                col <= col + 3'd1;
                for (int r = 0; r < 8; r++) begin
                    acc[r] <= sum[r];
                end
            end
            if (accept && last) begin
                out_valid <= 1'b1;
                for (int r = 0; r < 8; r++) begin
                    yr[r] <= sum[r];
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign y1  = yr[0];
    assign y3  = yr[1];
    assign y5  = yr[2];
    assign y7  = yr[3];
    assign y9  = yr[4];
    assign y11 = yr[5];
    assign y13 = yr[6];
    assign y15 = yr[7];

endmodule
